// File: rtl/cordic_iter_engine.sv
// Folded CORDIC engine: one transaction at a time, rotation / vectoring / bypass,
// per-transaction iteration count, quadrant pre-rotation and saturated outputs.
module cordic_iter_engine #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_ITER   = 12,
  parameter int unsigned TAG_WIDTH  = 4,
  localparam int unsigned ITW       = $clog2(NUM_ITER + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [1:0]            i_mode,
  input  logic [ITW-1:0]        i_iter,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic [DATA_WIDTH-1:0] i_x,
  input  logic [DATA_WIDTH-1:0] i_y,
  input  logic [DATA_WIDTH-1:0] i_z,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [DATA_WIDTH-1:0] o_x,
  output logic [DATA_WIDTH-1:0] o_y,
  output logic [DATA_WIDTH-1:0] o_z,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic                  o_busy
);

  localparam int unsigned XW   = DATA_WIDTH + 2;
  localparam int unsigned NTAB = 1 << ITW;
  // pi/2 in binary-angle units
  localparam logic [DATA_WIDTH-1:0] QuarterTurn = {2'b01, {(DATA_WIDTH - 2){1'b0}}};

  typedef enum logic [1:0] {StIdle, StPre, StIter, StDone} state_e;

  state_e                 r_state, w_state_d;
  logic signed [XW-1:0]   r_x, r_y;
  logic [DATA_WIDTH-1:0]  r_z;
  logic                   r_vec;
  logic [ITW-1:0]         r_n, r_i;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic [DATA_WIDTH-1:0]  r_ox, r_oy, r_oz;
  logic [TAG_WIDTH-1:0]   r_otag;

  logic                   w_accept, w_last, w_d;
  logic [ITW-1:0]         w_n;
  logic signed [XW-1:0]   w_pre_x, w_pre_y, w_it_x, w_it_y, w_xs, w_ys;
  logic [DATA_WIDTH-1:0]  w_pre_z, w_it_z;
  logic [DATA_WIDTH-1:0]  w_atan [NTAB];

  // Arctangent table, rounded to the nearest binary-angle LSB at elaboration.
  for (genvar g = 0; g < NTAB; g++) begin : g_atan
    localparam real AtanReal =
        $atan(1.0 / (2.0 ** g)) * (2.0 ** (DATA_WIDTH - 1)) / 3.14159265358979323846;
    localparam int AtanInt = $rtoi(AtanReal + 0.5);
    assign w_atan[g] = DATA_WIDTH'(AtanInt);
  end

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v[XW-1:DATA_WIDTH-1] == {3{v[XW-1]}}) return v[DATA_WIDTH-1:0];
    else if (v[XW-1])                         return {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    else                                      return {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  endfunction

  assign o_rdy    = (r_state == StIdle) && i_en && i_rst_n;
  assign o_vld    = (r_state == StDone) && i_en && i_rst_n;
  assign o_busy   = (r_state != StIdle);
  assign o_x      = r_ox;
  assign o_y      = r_oy;
  assign o_z      = r_oz;
  assign o_tag    = r_otag;
  assign w_accept = i_vld && o_rdy;
  assign w_last   = (r_i == r_n - ITW'(1));
  assign w_n      = (i_iter == '0 || i_iter > ITW'(NUM_ITER)) ? ITW'(NUM_ITER) : i_iter;

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = i_mode[1] ? StDone : StPre;
      StPre:   w_state_d = StIter;
      StIter:  if (w_last) w_state_d = StDone;
      StDone:  if (o_vld && i_rdy) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State register; frozen while disabled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  r_state <= StIdle;
    else if (i_en) r_state <= w_state_d;
  end

  // Quadrant pre-rotation so the micro-rotations only have to cover +-pi/2.
  always_comb begin
    w_pre_x = r_x;
    w_pre_y = r_y;
    w_pre_z = r_z;
    if (r_vec) begin
      if (r_x[XW-1]) begin
        if (!r_y[XW-1]) begin
          w_pre_x = r_y;
          w_pre_y = -r_x;
          w_pre_z = r_z + QuarterTurn;
        end else begin
          w_pre_x = -r_y;
          w_pre_y = r_x;
          w_pre_z = r_z - QuarterTurn;
        end
      end
    end else begin
      unique case (r_z[DATA_WIDTH-1 -: 2])
        2'b01: begin
          w_pre_x = -r_y;
          w_pre_y = r_x;
          w_pre_z = r_z - QuarterTurn;
        end
        2'b10: begin
          w_pre_x = r_y;
          w_pre_y = -r_x;
          w_pre_z = r_z + QuarterTurn;
        end
        default: ;
      endcase
    end
  end

  // One micro-rotation; d=+1 drives z toward 0 (rotation) or y toward 0 (vectoring).
  always_comb begin
    w_xs = r_x >>> r_i;
    w_ys = r_y >>> r_i;
    w_d  = r_vec ? r_y[XW-1] : !r_z[DATA_WIDTH-1];
    if (w_d) begin
      w_it_x = r_x - w_ys;
      w_it_y = r_y + w_xs;
      w_it_z = r_z - w_atan[r_i];
    end else begin
      w_it_x = r_x + w_ys;
      w_it_y = r_y - w_xs;
      w_it_z = r_z + w_atan[r_i];
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_vec  <= 1'b0;
      r_n    <= '0;
      r_i    <= '0;
      r_tag  <= '0;
      r_ox   <= '0;
      r_oy   <= '0;
      r_oz   <= '0;
      r_otag <= '0;
    end else if (i_en) begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_x   <= {{2{i_x[DATA_WIDTH-1]}}, i_x};
            r_y   <= {{2{i_y[DATA_WIDTH-1]}}, i_y};
            r_z   <= i_z;
            r_vec <= (i_mode == 2'b01);
            r_n   <= w_n;
            r_tag <= i_tag;
            if (i_mode[1]) begin
              r_ox   <= i_x;
              r_oy   <= i_y;
              r_oz   <= i_z;
              r_otag <= i_tag;
            end
          end
        end
        StPre: begin
          r_x <= w_pre_x;
          r_y <= w_pre_y;
          r_z <= w_pre_z;
          r_i <= '0;
        end
        StIter: begin
          r_x <= w_it_x;
          r_y <= w_it_y;
          r_z <= w_it_z;
          r_i <= r_i + ITW'(1);
          if (w_last) begin
            r_ox   <= sat(w_it_x);
            r_oy   <= sat(w_it_y);
            r_oz   <= w_it_z;
            r_otag <= r_tag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
